norm_sched: RTL and testbench

Shared normalization scheduler for the FPU add/FMA datapath. Arbitrates up to NUM_REQ mantissa-sum requesters onto one leading-zero-anticipation plus normalize-shift unit and runs one operation at a time through a small state machine. Each operation covers sum, LZA prediction, shift, an optional one-bit correction, and result hold. Requesters are FPU lanes that have finished alignment; the consumer is the rounding stage.

---
 rtl/norm_sched_pkg.sv | 20 ++
 rtl/norm_lzc.sv | 23 ++
 rtl/norm_sched.sv | 150 +++++++++++++++
 tb/tb_norm_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_sched_pkg.sv
// Shared types and width helpers for the normalization scheduler.
package norm_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRED,
        SHIFT,
        FIX,
        DONE
    } state_e;

    function automatic int shw_f(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/norm_lzc.sv
// Leading-one encoder: shamt = W-1-index(msb set in c), zero flag when c is all zero.
module norm_lzc #(
    parameter int W   = 24,
    parameter int SHW = 5
) (
    input  logic [W-1:0]   c,
    output logic [SHW-1:0] shamt,
    output logic           zero
);

    // Upward scan so the highest set bit is the last one written.
    always_comb begin
        shamt = '0;
        zero  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (c[i]) begin
                shamt = SHW'(W - 1 - i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Arbitrated LZA + normalize-shift scheduler, one operation in flight at a time.
// NORM_SCHED_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module norm_sched
    import norm_sched_pkg::*;
#(
    parameter int LEN     = 24,
    parameter int NUM_REQ = 4,
    parameter int SHW     = shw_f(LEN),
    parameter int IDW     = idw_f(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*LEN-1:0] req_a,
    input  logic [NUM_REQ*LEN-1:0] req_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN-1:0]         out_mant,
    output logic [SHW-1:0]         out_shamt,
    output logic                   out_zero,
    output logic [IDW-1:0]         out_id,
    output logic                   busy
);

    state_e         state, state_nxt;
    logic [LEN-1:0] a_q, b_q, mant_q;
    logic [SHW-1:0] shamt_q;
    logic           zero_q;
    logic [IDW-1:0] id_q;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;

`ifdef NORM_SCHED_RR_EN
    logic [IDW-1:0] ptr_q;

    // Descending scan: the requester closest to the pointer is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else if (state == IDLE && gnt_any)
            ptr_q <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(k);
            end
        end
    end
`endif

    logic [LEN-1:0] sum, p, nk, c, shifted;
    logic [SHW-1:0] lza_shamt;
    logic           lza_zero;

    assign sum     = a_q + b_q;
    assign p       = a_q ^ b_q;
    assign nk      = a_q | b_q;
    assign c       = {p[LEN-1:1] ^ nk[LEN-2:0], 1'b0};
    assign shifted = mant_q << shamt_q;

    norm_lzc #(.W(LEN), .SHW(SHW)) u_lzc (
        .c     (c),
        .shamt (lza_shamt),
        .zero  (lza_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: if (gnt_any) begin
                state_nxt = PRED;
                // Reset must mask the grant strobe even though state already reads IDLE.
                req_ready[gnt_id] = !rst;
            end
            PRED:  state_nxt = SHIFT;
            SHIFT: state_nxt = (mant_q == '0 || shifted[LEN-1]) ? DONE : FIX;
            FIX:   state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            mant_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    a_q  <= req_a[gnt_id*LEN +: LEN];
                    b_q  <= req_b[gnt_id*LEN +: LEN];
                    id_q <= gnt_id;
                end
                PRED: begin
                    mant_q  <= sum;
                    shamt_q <= lza_zero ? '0 : lza_shamt;
                    zero_q  <= 1'b0;
                end
                SHIFT: if (mant_q == '0) begin
                    shamt_q <= '0;
                    zero_q  <= 1'b1;
                end else begin
                    mant_q <= shifted;
                end
                FIX: begin
                    mant_q  <= mant_q << 1;
                    shamt_q <= shamt_q + SHW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_mant  = mant_q;
    assign out_shamt = shamt_q;
    assign out_zero  = zero_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_norm_sched.sv
// Self-checking bench for norm_sched (LEN=8, NUM_REQ=4) with a behavioural reference model.
module tb_norm_sched;

    localparam int LEN = 8, NR = 4, SHW = 4, IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*LEN-1:0] req_a, req_b;
    logic              out_valid, out_ready;
    logic [LEN-1:0]    out_mant;
    logic [SHW-1:0]    out_shamt;
    logic              out_zero;
    logic [IDW-1:0]    out_id;
    logic              busy;

    int n_cmp = 0, n_mis = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    norm_sched #(.LEN(LEN), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_shamt(out_shamt), .out_zero(out_zero),
        .out_id(out_id), .busy(busy)
    );

    // Reference: LZA equations applied bit by bit, then shift and one-step correction.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] m, output logic [3:0] sh,
                                  output logic z, output int lat);
        logic [7:0] cv, s;
        int top, shn;
        cv = 8'h00;
        for (int i = 1; i < 8; i++) cv[i] = (a[i] ^ b[i]) ^ (a[i-1] | b[i-1]);
        top = -1;
        for (int i = 0; i < 8; i++) if (cv[i]) top = i;
        shn = (top < 0) ? 0 : 7 - top;
        s = 8'((int'(a) + int'(b)) % 256);
        lat = 3;
        if (s == 8'h00) begin
            m = 8'h00; sh = 4'd0; z = 1'b1;
        end else begin
            z = 1'b0;
            m = 8'((int'(s) << shn) % 256);
            if (m[7] == 1'b0) begin
                m = 8'((int'(m) * 2) % 256);
                shn = shn + 1;
                lat = 4;
            end
            sh = 4'(shn);
        end
    endfunction

    function automatic int arb(input logic [NR-1:0] mask);
        int g = -1;
`ifdef NORM_SCHED_RR_EN
        for (int k = 0; k < NR; k++)
            if (g < 0 && mask[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
        if (g >= 0) ptr_m = (g + 1) % NR;
`else
        for (int k = NR - 1; k >= 0; k--) if (mask[k]) g = k;
`endif
        return g;
    endfunction

    task automatic set_lane(input int l, input logic [7:0] a, input logic [7:0] b);
        req_a[l*LEN +: LEN] = a;
        req_b[l*LEN +: LEN] = b;
    endtask

    // Drives a request and waits for out_valid; returns grant vector, idle wait and latency.
    task automatic launch(input logic [NR-1:0] vm, input bit hold,
                          output logic [NR-1:0] gnt, output int wait_n, output int lat);
        req_valid = vm; #1;
        wait_n = 0; lat = 0; gnt = '0;
        while (req_ready == '0 && wait_n < 30) begin @(negedge clk); #1; wait_n++; end
        if (req_ready == '0) begin
            n_cmp++; n_mis++;
            $display("FAIL grant_timeout got req_ready=%b after %0d cycles, need a grant", req_ready, wait_n);
            return;
        end
        gnt = req_ready;
        @(negedge clk); lat = 1;
        if (!hold) req_valid = '0;
        while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; out_ready = 1'b1; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        req_valid = 4'hF; #1;
        n_cmp++;
        if ({out_valid, req_ready, busy, out_mant, out_shamt, out_zero, out_id} !== '0) begin
            n_mis++;
            $display("FAIL reset_state got v=%b rdy=%b busy=%b mant=%h sh=%0d z=%b id=%0d need all zero",
                     out_valid, req_ready, busy, out_mant, out_shamt, out_zero, out_id);
        end
        req_valid = '0;
        @(negedge clk); rst = 1'b0; ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta[3] = '{8'h30, 8'h40, 8'h55};
        logic [7:0] tb[3] = '{8'h10, 8'hC1, 8'hAB};
        int         tl[3] = '{0, 1, 3};
        logic [14:0] te[3] = '{{8'h80, 4'd1, 1'b0, 2'd0}, {8'h80, 4'd7, 1'b0, 2'd1}, {8'h00, 4'd0, 1'b1, 2'd3}};
        int         tlat[3] = '{3, 4, 3};
        logic [NR-1:0] gnt, vm;
        int wn, lat, g;
        for (int i = 0; i < 3; i++) begin
            set_lane(tl[i], ta[i], tb[i]);
            vm = '0; vm[tl[i]] = 1'b1;
            g = arb(vm);
            launch(vm, 0, gnt, wn, lat);
            n_cmp++;
            if ({out_mant, out_shamt, out_zero, out_id} !== te[i]) begin
                n_mis++;
                $display("FAIL directed_%0d_result got %h need %h", i, {out_mant, out_shamt, out_zero, out_id}, te[i]);
            end
            n_cmp++;
            if (lat !== tlat[i] || gnt !== NR'(1 << g)) begin
                n_mis++;
                $display("FAIL directed_%0d_timing got lat=%0d gnt=%b need lat=%0d gnt=%b", i, lat, gnt, tlat[i], NR'(1 << g));
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin n_mis++; $display("FAIL directed_%0d_idle got busy=%b need 0", i, busy); end
        end
    endtask

    task automatic test_random();
        logic [7:0] la[NR], lb[NR], em;
        logic [3:0] es;
        logic ez;
        logic [NR-1:0] mask, gnt;
        int g, wn, lat, elat;
        for (int it = 0; it < 40; it++) begin
            mask = NR'($urandom_range(1, 15));
            for (int l = 0; l < NR; l++) begin
                la[l] = 8'($urandom);
                lb[l] = ($urandom_range(0, 5) == 0) ? 8'(-la[l]) : 8'($urandom);
                set_lane(l, la[l], lb[l]);
            end
            g = arb(mask);
            model(la[g], lb[g], em, es, ez, elat);
            launch(mask, 0, gnt, wn, lat);
            n_cmp++;
            if (gnt !== NR'(1 << g) || lat !== elat) begin
                n_mis++;
                $display("FAIL rand_%0d_grant got gnt=%b lat=%0d need gnt=%b lat=%0d", it, gnt, lat, NR'(1 << g), elat);
            end
            n_cmp++;
            if ({out_mant, out_shamt, out_zero, out_id} !== {em, es, ez, 2'(g)}) begin
                n_mis++;
                $display("FAIL rand_%0d_result a=%h b=%h got %h/%0d/%b/%0d need %h/%0d/%b/%0d", it, la[g], lb[g],
                         out_mant, out_shamt, out_zero, out_id, em, es, ez, g);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] gnt;
        int g, wn, lat;
        rst = 1'b1; @(negedge clk); rst = 1'b0; ptr_m = 0;
        for (int l = 0; l < NR; l++) set_lane(l, 8'h30, 8'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = arb(4'b0101);
            launch(4'b0101, 1, gnt, wn, lat);
            n_cmp++;
            if (gnt !== NR'(1 << g) || lat !== 3 || (i > 0 && wn !== 1)) begin
                n_mis++;
                $display("FAIL b2b_%0d got gnt=%b lat=%0d wait=%0d need gnt=%b lat=3 wait=1", i, gnt, lat, wn, NR'(1 << g));
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [NR-1:0] gnt;
        logic [14:0] snap;
        logic [7:0] em;
        logic [3:0] es;
        logic ez;
        int g, wn, lat, elat;
        for (int l = 0; l < NR; l++) set_lane(l, 8'h40, 8'hC1);
        model(8'h40, 8'hC1, em, es, ez, elat);
        out_ready = 1'b0;
        g = arb(4'b0010);
        launch(4'b0010, 0, gnt, wn, lat);
        snap = {out_mant, out_shamt, out_zero, out_id};
        n_cmp++;
        if (snap !== {em, es, ez, 2'(g)} || !out_valid) begin
            n_mis++;
            $display("FAIL stall_entry got v=%b %h need v=1 %h", out_valid, snap, {em, es, ez, 2'(g)});
        end
        req_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, req_ready, out_mant, out_shamt, out_zero, out_id} !== {1'b1, 4'b0000, snap}) begin
                n_mis++;
                $display("FAIL stall_hold_%0d got v=%b rdy=%b %h need v=1 rdy=0000 %h", i, out_valid, req_ready,
                         {out_mant, out_shamt, out_zero, out_id}, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        g = arb(4'hF);
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== NR'(1 << g)) begin
            n_mis++;
            $display("FAIL stall_release got busy=%b rdy=%b need busy=0 rdy=%b", busy, req_ready, NR'(1 << g));
        end
        launch(4'hF, 0, gnt, wn, lat);
        n_cmp++;
        if ({out_mant, out_shamt, out_zero, out_id} !== {em, es, ez, 2'(g)} || lat !== elat) begin
            n_mis++;
            $display("FAIL stall_next got %h lat=%0d need %h lat=%0d", {out_mant, out_shamt, out_zero, out_id}, lat,
                     {em, es, ez, 2'(g)}, elat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] gnt;
        int g, n, wn, lat;
        for (int l = 0; l < NR; l++) set_lane(l, 8'h30, 8'h10);
        g = arb(4'b0100);
        req_valid = 4'b0100; #1;
        n = 0;
        while (req_ready == '0 && n < 30) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL rstmid_in_shift got busy=%b v=%b need busy=1 v=0", busy, out_valid);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({out_valid, req_ready, busy, out_mant, out_shamt, out_zero, out_id} !== '0) begin
            n_mis++;
            $display("FAIL rstmid_clear got v=%b rdy=%b busy=%b mant=%h sh=%0d z=%b id=%0d need all zero",
                     out_valid, req_ready, busy, out_mant, out_shamt, out_zero, out_id);
        end
        @(negedge clk); rst = 1'b0; req_valid = '0; ptr_m = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_no_regrant got busy=%b need 0", busy); end
        g = arb(4'hF);
        launch(4'hF, 0, gnt, wn, lat);
        n_cmp++;
        if (gnt !== NR'(1 << g) || {out_mant, out_shamt, out_zero, out_id} !== {8'h80, 4'd1, 1'b0, 2'(g)}) begin
            n_mis++;
            $display("FAIL rstmid_ptr got gnt=%b %h need gnt=%b %h", gnt, {out_mant, out_shamt, out_zero, out_id},
                     NR'(1 << g), {8'h80, 4'd1, 1'b0, 2'(g)});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
